adder_arbiter_half_precision: RTL and testbench

- Shares one combinational `adderhalfprecision` instance among N requesters.
- Round-robin arbitration, per-requester valid/ready handshake, registered operands, registered tagged result.
- Sits between pipeline units issuing FP16 adds (vertex/shading stages) and the single adder datapath.

---
 rtl/adder_arbiter_half_precision_pkg.sv | 23 ++
 rtl/adder_rr_pick.sv | 28 ++
 rtl/adderhalfprecision.sv | 92 +++++++++
 rtl/adder_arbiter_half_precision.sv | 109 ++++++++++
 tb/tb_adder_arbiter_half_precision.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_half_precision_pkg.sv
// Shared FSM encodings, FP16 constants and operand struct for the FP16 adder arbiter.
// The optional subtract feature is enabled by defining ADDER_ARB_SUB_EN.
package adder_arbiter_half_precision_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam int FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_ONE   = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_TWO   = 16'h4000;
  localparam logic [FP16_W-1:0] FP16_THREE = 16'h4200;
  localparam logic [FP16_W-1:0] FP16_QNAN  = 16'h7E00;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
  } arb_op_t;

endpackage

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_Ptr, wrapping modulo N_REQ.
module adder_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_Req,
  input  logic [ID_W-1:0]  i_Ptr,
  output logic [N_REQ-1:0] o_Grant,
  output logic [ID_W-1:0]  o_Idx,
  output logic             o_Any
);

  logic [ID_W-1:0] w_Pos;

  // Walk the search order backwards so the highest-priority hit is written last.
  always_comb begin
    o_Grant = '0;
    o_Idx   = '0;
    w_Pos   = '0;
    o_Any   = |i_Req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_Pos = ID_W'((int'(i_Ptr) + k) % N_REQ);
      if (i_Req[w_Pos]) o_Idx = w_Pos;
    end
    if (o_Any) o_Grant[o_Idx] = 1'b1;
  end

endmodule

// File: rtl/adderhalfprecision.sv
// Combinational IEEE-754 binary16 adder with round-to-nearest-even and subnormal support.
module adderhalfprecision
  import adder_arbiter_half_precision_pkg::*;
(
  input  logic [FP16_W-1:0] i_A,
  input  logic [FP16_W-1:0] i_B,
  output logic [FP16_W-1:0] o_Sum
);

  logic [15:0] w_X, w_Y;
  logic [4:0]  w_ExpX, w_ExpY, w_Diff;
  logic [13:0] w_ManX, w_ManY, w_ManYSh, w_Man;
  logic [14:0] w_Raw;
  logic [5:0]  w_Exp;
  logic [11:0] w_Rnd;
  logic        w_Sticky, w_Up;
  logic        w_NanA, w_NanB, w_InfA, w_InfB;

  always_comb begin
    w_NanA   = (i_A[14:10] == 5'h1f) && (i_A[9:0] != 10'd0);
    w_NanB   = (i_B[14:10] == 5'h1f) && (i_B[9:0] != 10'd0);
    w_InfA   = (i_A[14:10] == 5'h1f) && (i_A[9:0] == 10'd0);
    w_InfB   = (i_B[14:10] == 5'h1f) && (i_B[9:0] == 10'd0);
    w_Sticky = 1'b0;
    w_ManYSh = '0;
    w_Raw    = '0;
    w_Man    = '0;

    // X always holds the larger magnitude so the result sign is X's sign.
    if (i_A[14:0] >= i_B[14:0]) begin
      w_X = i_A;
      w_Y = i_B;
    end else begin
      w_X = i_B;
      w_Y = i_A;
    end
    w_ExpX = (w_X[14:10] == 5'd0) ? 5'd1 : w_X[14:10];
    w_ExpY = (w_Y[14:10] == 5'd0) ? 5'd1 : w_Y[14:10];
    w_ManX = {|w_X[14:10], w_X[9:0], 3'b000};
    w_ManY = {|w_Y[14:10], w_Y[9:0], 3'b000};
    w_Diff = w_ExpX - w_ExpY;

    if (w_Diff >= 5'd14) begin
      w_ManYSh = {13'd0, |w_ManY};
    end else begin
      w_Sticky = |(w_ManY & ((14'd1 << w_Diff) - 14'd1));
      w_ManYSh = (w_ManY >> w_Diff) | {13'd0, w_Sticky};
    end

    w_Exp = {1'b0, w_ExpX};
    if (w_X[15] == w_Y[15]) begin
      w_Raw = {1'b0, w_ManX} + {1'b0, w_ManYSh};
      if (w_Raw[14]) begin
        w_Man = {w_Raw[14:2], |w_Raw[1:0]};
        w_Exp = w_Exp + 6'd1;
      end else begin
        w_Man = w_Raw[13:0];
      end
    end else begin
      w_Raw = {1'b0, w_ManX} - {1'b0, w_ManYSh};
      w_Man = w_Raw[13:0];
      // Normalise left, but stop at the minimum exponent to produce subnormals.
      for (int i = 0; i < 13; i++) begin
        if (!w_Man[13] && (w_Exp > 6'd1)) begin
          w_Man = w_Man << 1;
          w_Exp = w_Exp - 6'd1;
        end
      end
    end

    w_Up  = w_Man[2] & ((|w_Man[1:0]) | w_Man[3]);
    w_Rnd = {1'b0, w_Man[13:3]} + {11'd0, w_Up};
    if (w_Rnd[11]) begin
      w_Rnd = w_Rnd >> 1;
      w_Exp = w_Exp + 6'd1;
    end

    if (w_NanA || w_NanB || (w_InfA && w_InfB && (i_A[15] != i_B[15])))
      o_Sum = FP16_QNAN;
    else if (w_InfA)
      o_Sum = i_A;
    else if (w_InfB)
      o_Sum = i_B;
    else if (w_Rnd == 12'd0)
      o_Sum = {w_X[15] & w_Y[15], 15'd0};
    else if (w_Exp >= 6'd31)
      o_Sum = {w_X[15], 5'h1f, 10'd0};
    else
      o_Sum = {w_X[15], (w_Rnd[10] ? w_Exp[4:0] : 5'd0), w_Rnd[9:0]};
  end

endmodule

// File: rtl/adder_arbiter_half_precision.sv
// Round-robin arbiter sharing one FP16 adder among N_REQ requesters (IDLE -> EXEC -> RESP).
// Define ADDER_ARB_SUB_EN to add the per-requester i_ReqSub port (A-B when set).
module adder_arbiter_half_precision
  import adder_arbiter_half_precision_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [N_REQ-1:0]          i_ReqValid,
  input  logic [FP16_W*N_REQ-1:0]   i_ReqAddend1,
  input  logic [FP16_W*N_REQ-1:0]   i_ReqAddend2,
`ifdef ADDER_ARB_SUB_EN
  input  logic [N_REQ-1:0]          i_ReqSub,
`endif
  output logic [N_REQ-1:0]          o_ReqReady,
  output logic                      o_RespValid,
  output logic [ID_W-1:0]           o_RespId,
  output logic [FP16_W-1:0]         o_RespSum,
  input  logic                      i_RespReady
);

  arb_state_t                    r_State;
  logic [ID_W-1:0]               r_Ptr;
  logic [ID_W-1:0]               r_Id;
  arb_op_t                       r_Op;
  logic                          r_RespValid;
  logic [FP16_W-1:0]             r_RespSum;

  logic [N_REQ-1:0][FP16_W-1:0]  w_A, w_B;
  logic [N_REQ-1:0]              w_Grant;
  logic [ID_W-1:0]               w_Idx;
  logic                          w_Any;
  logic [FP16_W-1:0]             w_OpB, w_Sum;

  assign w_A = i_ReqAddend1;
  assign w_B = i_ReqAddend2;

  adder_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_Req   (i_ReqValid),
    .i_Ptr   (r_Ptr),
    .o_Grant (w_Grant),
    .o_Idx   (w_Idx),
    .o_Any   (w_Any)
  );

  // Grant is visible only while idle and out of reset; the transfer completes on the next edge.
  assign o_ReqReady = ((r_State == ARB_IDLE) && !i_Reset) ? w_Grant : '0;

`ifdef ADDER_ARB_SUB_EN
  logic r_Sub;
  assign w_OpB = {r_Op.b[15] ^ r_Sub, r_Op.b[14:0]};
`else
  assign w_OpB = r_Op.b;
`endif

  adderhalfprecision u_add (
    .i_A   (r_Op.a),
    .i_B   (w_OpB),
    .o_Sum (w_Sum)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= ARB_IDLE;
      r_Ptr       <= '0;
      r_Id        <= '0;
      r_Op        <= '0;
      r_RespValid <= 1'b0;
      r_RespSum   <= '0;
`ifdef ADDER_ARB_SUB_EN
      r_Sub       <= 1'b0;
`endif
    end else begin
      case (r_State)
        ARB_IDLE: begin
          if (w_Any) begin
            r_Op.a  <= w_A[w_Idx];
            r_Op.b  <= w_B[w_Idx];
            r_Id    <= w_Idx;
            r_Ptr   <= (w_Idx == ID_W'(N_REQ - 1)) ? '0 : w_Idx + 1'b1;
`ifdef ADDER_ARB_SUB_EN
            r_Sub   <= i_ReqSub[w_Idx];
`endif
            r_State <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          r_RespSum   <= w_Sum;
          r_RespValid <= 1'b1;
          r_State     <= ARB_RESP;
        end
        ARB_RESP: begin
          if (i_RespReady) begin
            r_RespValid <= 1'b0;
            r_State     <= ARB_IDLE;
          end
        end
        default: r_State <= ARB_IDLE;
      endcase
    end
  end

  assign o_RespValid = r_RespValid;
  assign o_RespId    = r_Id;
  assign o_RespSum   = r_RespSum;

endmodule

// File: tb/tb_adder_arbiter_half_precision.sv
// Scoreboard bench for adder_arbiter_half_precision: expected responses queued at grant, checked at handshake.
`timescale 1ns/1ps
module tb_adder_arbiter_half_precision;
  import adder_arbiter_half_precision_pkg::*;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] sum;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] add_a = '0;
  logic [63:0] add_b = '0;
  logic [3:0]  req_sub = '0;
  logic        resp_ready = 1'b1;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_sum;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  int          cyc_at = 0;
  resp_t       sb[$];
  resp_t       m_exp;
  logic [15:0] exp_sum [4];

  adder_arbiter_half_precision #(.N_REQ(4), .ID_W(2)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_ReqValid   (req_valid),
    .i_ReqAddend1 (add_a),
    .i_ReqAddend2 (add_b),
`ifdef ADDER_ARB_SUB_EN
    .i_ReqSub     (req_sub),
`endif
    .o_ReqReady   (req_ready),
    .o_RespValid  (resp_valid),
    .o_RespId     (resp_id),
    .o_RespSum    (resp_sum),
    .i_RespReady  (resp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard monitor: grant legality every cycle, response contents at each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != 4'b0)) begin
        n_err++;
        $display("FAIL grant_legal: ReqReady=%b with ReqValid=%b", req_ready, req_valid);
      end
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got id=%0d sum=%h, none pending", resp_id, resp_sum);
        end else begin
          m_exp = sb.pop_front();
          if ({resp_id, resp_sum} !== {m_exp.id, m_exp.sum}) begin
            n_err++;
            $display("FAIL resp_data: got id=%0d sum=%h, want id=%0d sum=%h",
                     resp_id, resp_sum, m_exp.id, m_exp.sum);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] e);
    add_a[k*16 +: 16] = a;
    add_b[k*16 +: 16] = b;
    req_sub[k]        = s;
    exp_sum[k]        = e;
    req_valid[k]      = 1'b1;
  endtask

  // One cycle of requester behaviour: observe grant, queue its expected result, withdraw accepted valid.
  task automatic tick(output logic [3:0] g);
    @(negedge clk);
    g = req_ready;
    for (int k = 0; k < 4; k++)
      if (g[k]) sb.push_back('{id: 2'(k), sum: exp_sum[k]});
    cyc_at = cyc_cnt;
    @(posedge clk); #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int c);
    logic [3:0] t;
    t = '0;
    c = -1;
    for (int i = 0; i < 30; i++) begin
      tick(t);
      if (t != 4'b0) begin
        c = cyc_at;
        break;
      end
    end
    g = t;
  endtask

  task automatic drain(input int n);
    logic [3:0] t;
    repeat (n) tick(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_req(0, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    set_req(2, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    #12;
    n_cmp++; if (req_ready !== 4'b0)   begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_id !== 2'd0)     begin n_err++; $display("FAIL rst_id: got %0d want 0", resp_id); end
    n_cmp++; if (resp_sum !== 16'h0)   begin n_err++; $display("FAIL rst_sum: got %h want 0000", resp_sum); end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    int c;
    set_req(1, FP16_ONE, FP16_TWO, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b want 0010", g); end
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid} !== 5'b0) begin
      n_err++; $display("FAIL single_pulse: ReqReady=%b RespValid=%b want 0000/0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd1, FP16_THREE}) begin
      n_err++; $display("FAIL single_resp: got v=%b id=%0d sum=%h want v=1 id=1 sum=4200",
                        resp_valid, resp_id, resp_sum);
    end
    @(posedge clk); #1;
    // Pointer should now sit at 2, so 2 beats 1.
    set_req(1, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    set_req(2, FP16_ONE, FP16_TWO, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL single_ptr: got %b want 0100", g); end
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL single_ptr2: got %b want 0010", g); end
    drain(4);
  endtask

  task automatic test_all_four();
    logic [3:0] g;
    int c, prev;
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g, c);
      n_cmp++;
      if (g !== 4'(1 << i)) begin n_err++; $display("FAIL all4_order%0d: got %b want %b", i, g, 4'(1 << i)); end
      if (i > 0) begin
        n_cmp++;
        if (c - prev != 3) begin n_err++; $display("FAIL all4_spacing%0d: got %0d cycles want 3", i, c - prev); end
      end
      prev = c;
    end
    drain(4);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL all4_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_back_pressure();
    logic [3:0] g;
    int c, c0;
    resp_ready = 1'b0;
    set_req(0, FP16_ONE, FP16_TWO, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL bp_grant: got %b want 0001", g); end
    set_req(1, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({resp_valid, resp_id, resp_sum, req_ready} !== {1'b1, 2'd0, FP16_THREE, 4'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b id=%0d sum=%h rdy=%b want v=1 id=0 sum=4200 rdy=0000",
                          i, resp_valid, resp_id, resp_sum, req_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    c0 = cyc_cnt;
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got %b want 0010", g); end
    n_cmp++; if (c != c0 + 1) begin n_err++; $display("FAIL bp_next_time: got cycle %0d want %0d", c, c0 + 1); end
    drain(4);
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    int c;
    set_req(2, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL wrap_setup: got %b want 0100", g); end
    set_req(0, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    set_req(3, FP16_ONE, FP16_TWO, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b want 1000", g); end
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL wrap_second: got %b want 0001", g); end
    drain(4);
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    int c;
    set_req(1, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL rmid_grant: got %b want 0010", g); end
    rst = 1'b1;
    sb.delete();
    #1;
    n_cmp++;
    if ({resp_valid, resp_id, resp_sum, req_ready} !== {1'b0, 2'd0, 16'h0, 4'b0}) begin
      n_err++; $display("FAIL rmid_outputs: got v=%b id=%0d sum=%h rdy=%b want all zero",
                        resp_valid, resp_id, resp_sum, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_noresp%0d: got %b want 0", i, resp_valid); end
      @(posedge clk); #1;
    end
    set_req(0, FP16_ONE, FP16_ONE, 1'b0, FP16_TWO);
    set_req(2, FP16_TWO, FP16_ONE, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL rmid_ptr0: got %b want 0001", g); end
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL rmid_next: got %b want 0100", g); end
    drain(4);
  endtask

`ifdef ADDER_ARB_SUB_EN
  task automatic test_sub();
    logic [3:0] g;
    int c;
    set_req(0, FP16_TWO, FP16_ONE, 1'b1, FP16_ONE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL sub_grant: got %b want 0001", g); end
    drain(4);
    set_req(0, FP16_TWO, FP16_ONE, 1'b0, FP16_THREE);
    wait_grant(g, c);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL add_grant: got %b want 0001", g); end
    drain(4);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_pressure();
    test_wrap();
    test_reset_mid();
`ifdef ADDER_ARB_SUB_EN
    test_sub();
`endif
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL final_pending: %0d responses never seen, want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
